// File: rtl/aes128_enc_round_engine.sv
// Iterative AES-128 encryption engine: one cipher round per clock over externally supplied round keys.
// Includes the GF(2^8) helper package and the combinational s_box used for SubBytes.
package aes128_gf_pkg;
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = 8'h00;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      else      acc = acc;
      sh = xtime(sh);
    end
    return acc;
  endfunction
endpackage

module s_box (
  input  logic [7:0] a,
  output logic [7:0] y
);
  import aes128_gf_pkg::*;

  // Multiplicative inverse as a^254 via an addition chain; 0 maps to 0 naturally.
  logic [7:0] x2_s, x3_s, x6_s, x7_s, x14_s, x15_s, x30_s, x31_s;
  logic [7:0] x62_s, x63_s, x126_s, x127_s, inv_s;
  assign x2_s   = gf_mul(a, a);
  assign x3_s   = gf_mul(x2_s, a);
  assign x6_s   = gf_mul(x3_s, x3_s);
  assign x7_s   = gf_mul(x6_s, a);
  assign x14_s  = gf_mul(x7_s, x7_s);
  assign x15_s  = gf_mul(x14_s, a);
  assign x30_s  = gf_mul(x15_s, x15_s);
  assign x31_s  = gf_mul(x30_s, a);
  assign x62_s  = gf_mul(x31_s, x31_s);
  assign x63_s  = gf_mul(x62_s, a);
  assign x126_s = gf_mul(x63_s, x63_s);
  assign x127_s = gf_mul(x126_s, a);
  assign inv_s  = gf_mul(x127_s, x127_s);

  assign y = inv_s ^ {inv_s[6:0], inv_s[7]} ^ {inv_s[5:0], inv_s[7:6]}
           ^ {inv_s[4:0], inv_s[7:5]} ^ {inv_s[3:0], inv_s[7:4]} ^ 8'h63;
endmodule

module aes128_enc_round_engine #(
  parameter int WIDTH    = 128,
  parameter int N_ROUNDS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             keys_valid,
  input  logic             start,
  input  logic [WIDTH-1:0] pt,
  input  logic [WIDTH-1:0] k0,
  input  logic [WIDTH-1:0] k1,
  input  logic [WIDTH-1:0] k2,
  input  logic [WIDTH-1:0] k3,
  input  logic [WIDTH-1:0] k4,
  input  logic [WIDTH-1:0] k5,
  input  logic [WIDTH-1:0] k6,
  input  logic [WIDTH-1:0] k7,
  input  logic [WIDTH-1:0] k8,
  input  logic [WIDTH-1:0] k9,
  input  logic [WIDTH-1:0] k10,
  output logic             busy,
  output logic             ct_valid,
  output logic [WIDTH-1:0] ct
);
  import aes128_gf_pkg::*;

  if (WIDTH != 128) begin : g_bad_width
    $error("aes128_enc_round_engine supports WIDTH=128 only");
  end
  if (N_ROUNDS != 10) begin : g_bad_rounds
    $error("aes128_enc_round_engine supports N_ROUNDS=10 only");
  end

  localparam logic [3:0] LAST_ROUND = 4'(N_ROUNDS);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ROUND = 2'd1, S_DONE = 2'd2} fsm_t;

  fsm_t             fsm_r, fsm_next_s;
  logic [WIDTH-1:0] blk_r, blk_next_s;
  logic [3:0]       round_r, round_next_s;
  logic             busy_r, busy_next_s;
  logic             ct_valid_r, ct_valid_next_s;
  logic [WIDTH-1:0] ct_r, ct_next_s;

  logic [7:0]       sb_s [16];
  logic [7:0]       sr_s [16];
  logic [7:0]       mc_s [16];
  logic [WIDTH-1:0] sr_flat_s, mc_flat_s, rk_s, round_out_s;

  // Byte i sits at blk_r[127-8i -: 8]; state column c holds bytes 4c..4c+3.
  for (genvar i = 0; i < 16; i++) begin : g_sbox
    s_box u_sbox (.a(blk_r[WIDTH-1-8*i -: 8]), .y(sb_s[i]));
    assign sr_flat_s[WIDTH-1-8*i -: 8] = sr_s[i];
    assign mc_flat_s[WIDTH-1-8*i -: 8] = mc_s[i];
  end

  for (genvar c = 0; c < 4; c++) begin : g_shift_col
    for (genvar r = 0; r < 4; r++) begin : g_shift_row
      assign sr_s[4*c+r] = sb_s[4*((c+r)%4)+r];
    end
  end

  for (genvar c = 0; c < 4; c++) begin : g_mix
    logic [7:0] a0, a1, a2, a3;
    assign a0 = sr_s[4*c];
    assign a1 = sr_s[4*c+1];
    assign a2 = sr_s[4*c+2];
    assign a3 = sr_s[4*c+3];
    assign mc_s[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    assign mc_s[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    assign mc_s[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    assign mc_s[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
  end

  // Round key select; counter values outside 1..10 never occur while rounds run.
  always_comb begin
    case (round_r)
      4'd1:    rk_s = k1;
      4'd2:    rk_s = k2;
      4'd3:    rk_s = k3;
      4'd4:    rk_s = k4;
      4'd5:    rk_s = k5;
      4'd6:    rk_s = k6;
      4'd7:    rk_s = k7;
      4'd8:    rk_s = k8;
      4'd9:    rk_s = k9;
      4'd10:   rk_s = k10;
      default: rk_s = {WIDTH{1'b0}};
    endcase
  end

  assign round_out_s = ((round_r == LAST_ROUND) ? sr_flat_s : mc_flat_s) ^ rk_s;

  // Next-state logic; ct is captured together with the final round so it is valid during DONE.
  always_comb begin
    fsm_next_s      = fsm_r;
    blk_next_s      = blk_r;
    round_next_s    = round_r;
    busy_next_s     = busy_r;
    ct_valid_next_s = 1'b0;
    ct_next_s       = ct_r;
    case (fsm_r)
      S_IDLE: begin
        if (start && keys_valid) begin
          fsm_next_s   = S_ROUND;
          blk_next_s   = pt ^ k0;
          round_next_s = 4'd1;
          busy_next_s  = 1'b1;
        end else begin
          fsm_next_s = S_IDLE;
        end
      end
      S_ROUND: begin
        blk_next_s = round_out_s;
        if (round_r == LAST_ROUND) begin
          fsm_next_s      = S_DONE;
          round_next_s    = 4'd0;
          busy_next_s     = 1'b0;
          ct_valid_next_s = 1'b1;
          ct_next_s       = round_out_s;
        end else begin
          round_next_s = round_r + 4'd1;
        end
      end
      S_DONE:  fsm_next_s = S_IDLE;
      default: fsm_next_s = S_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_r      <= S_IDLE;
      blk_r      <= {WIDTH{1'b0}};
      round_r    <= 4'd0;
      busy_r     <= 1'b0;
      ct_valid_r <= 1'b0;
      ct_r       <= {WIDTH{1'b0}};
    end else begin
      fsm_r      <= fsm_next_s;
      blk_r      <= blk_next_s;
      round_r    <= round_next_s;
      busy_r     <= busy_next_s;
      ct_valid_r <= ct_valid_next_s;
      ct_r       <= ct_next_s;
    end
  end

  assign busy     = busy_r;
  assign ct_valid = ct_valid_r;
  assign ct       = ct_r;
endmodule

// File: tb/tb_aes128_enc_round_engine.sv
// Self-checking bench for aes128_enc_round_engine: a byte-level AES reference model with its own
// key expansion and table-generated S-box, compared against the DUT on every cycle.
module tb_aes128_enc_round_engine;
  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_R1   = 128'ha49c7ff2689f352b6b5bea43026a5049;
  localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic keys_valid = 1'b0;
  logic start = 1'b0;
  logic [127:0] pt = 128'h0;
  logic [127:0] rk [0:10];
  logic busy, ct_valid;
  logic [127:0] ct;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  aes128_enc_round_engine dut (
    .clk(clk), .rst(rst), .keys_valid(keys_valid), .start(start), .pt(pt),
    .k0(rk[0]), .k1(rk[1]), .k2(rk[2]), .k3(rk[3]), .k4(rk[4]), .k5(rk[5]),
    .k6(rk[6]), .k7(rk[7]), .k8(rk[8]), .k9(rk[9]), .k10(rk[10]),
    .busy(busy), .ct_valid(ct_valid), .ct(ct)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  logic [7:0] sbox [0:255];

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  // S-box generated by walking generator 3 and its inverse in lockstep.
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01; q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox[0] = 8'h63;
  endtask

  function automatic logic [127:0] round_key(input logic [127:0] key, input int r);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0] rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic logic [127:0] cipher(input logic [127:0] key, input logic [127:0] p, input int upto);
    logic [7:0] st [16];
    logic [7:0] t [16];
    logic [7:0] u [16];
    logic [127:0] k, res;
    k = round_key(key, 0);
    for (int i = 0; i < 16; i++) st[i] = p[127-8*i -: 8] ^ k[127-8*i -: 8];
    for (int rd = 1; rd <= upto; rd++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox[st[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) u[4*c+r] = t[4*((c+r)%4)+r];
      for (int c = 0; c < 4; c++) begin
        if (rd < 10) begin
          st[4*c]   = gmul(u[4*c],8'h02) ^ gmul(u[4*c+1],8'h03) ^ u[4*c+2] ^ u[4*c+3];
          st[4*c+1] = u[4*c] ^ gmul(u[4*c+1],8'h02) ^ gmul(u[4*c+2],8'h03) ^ u[4*c+3];
          st[4*c+2] = u[4*c] ^ u[4*c+1] ^ gmul(u[4*c+2],8'h02) ^ gmul(u[4*c+3],8'h03);
          st[4*c+3] = gmul(u[4*c],8'h03) ^ u[4*c+1] ^ u[4*c+2] ^ gmul(u[4*c+3],8'h02);
        end else begin
          for (int r = 0; r < 4; r++) st[4*c+r] = u[4*c+r];
        end
      end
      k = round_key(key, rd);
      for (int i = 0; i < 16; i++) st[i] = st[i] ^ k[127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = st[i];
    return res;
  endfunction

  logic [127:0] cur_key = 128'h0;

  task automatic set_key(input logic [127:0] key);
    cur_key = key;
    for (int r = 0; r <= 10; r++) rk[r] = round_key(key, r);
  endtask

  // Cycle model: cnt counts edges since accept (1..10 busy, 11 = result visible, 0 = idle).
  int cnt = 0;
  bit ready = 1'b0;
  logic [127:0] pend = 128'h0;
  logic [127:0] exp_ct = 128'h0;

  always @(posedge clk) begin
    if (rst) begin
      cnt = 0; exp_ct = 128'h0; ready = 1'b1;
    end else if (cnt == 0) begin
      if (start && keys_valid) begin
        cnt = 1;
        pend = cipher(cur_key, pt, 10);
      end
    end else if (cnt == 11) begin
      cnt = 0;
    end else begin
      cnt++;
      if (cnt == 11) exp_ct = pend;
    end
  end

  always @(negedge clk) begin
    if (ready) begin
      chk("busy", 128'(busy), 128'(cnt >= 1 && cnt <= 10));
      chk("ct_valid", 128'(ct_valid), 128'(cnt == 11));
      chk("ct", ct, exp_ct);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic run_one(input string tag, input logic [127:0] key, input logic [127:0] p,
                         input logic [127:0] exp, input bit probe);
    int lat = -1;
    int nbusy = 0;
    set_key(key);
    pt = p; keys_valid = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pt = ~p;
    for (int i = 1; i <= 14; i++) begin
      if (busy) nbusy++;
      if (probe && i == 2) chk({tag, "_round1"}, dut.blk_r, B_R1);
      if (probe && i == 3) keys_valid = 1'b0;
      if (ct_valid && lat < 0) begin
        lat = i;
        chk({tag, "_ct"}, ct, exp);
      end
      @(negedge clk);
    end
    keys_valid = 1'b1;
    chk({tag, "_latency"}, 128'(lat), 128'(11));
    chk({tag, "_busy_cycles"}, 128'(nbusy), 128'(10));
  endtask

  initial begin
    int pulse_at [$];
    build_sbox();
    set_key(C1_KEY);

    chk("model_c1", cipher(C1_KEY, C1_PT, 10), C1_CT);
    chk("model_b", cipher(B_KEY, B_PT, 10), B_CT);
    chk("model_b_r1", cipher(B_KEY, B_PT, 1), B_R1);
    chk("model_zero", cipher(128'h0, 128'h0, 10), Z_CT);

    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_ct", ct, 128'h0);
    chk("reset_busy", 128'(busy), 128'h0);
    rst = 1'b0;

    // start without valid keys must be ignored
    start = 1'b1; keys_valid = 1'b0; pt = C1_PT;
    repeat (20) @(negedge clk);
    chk("nokeys_ct", ct, 128'h0);
    chk("nokeys_busy", 128'(busy), 128'h0);
    start = 1'b0;

    // reset wins over start on the same edge
    rst = 1'b1; start = 1'b1; keys_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk("rst_start_busy", 128'(busy), 128'h0);
    repeat (2) @(negedge clk);

    run_one("c1", C1_KEY, C1_PT, C1_CT, 1'b0);
    run_one("b", B_KEY, B_PT, B_CT, 1'b1);

    // start held high: back-to-back encryptions, key/pt switched after the first result
    set_key(C1_KEY); pt = C1_PT; keys_valid = 1'b1; start = 1'b1;
    for (int i = 1; i <= 36; i++) begin
      @(negedge clk);
      if (ct_valid) pulse_at.push_back(i);
      if (i == 11) begin
        chk("b2b_ct1", ct, C1_CT);
        set_key(128'h0); pt = 128'h0;
      end
      if (i == 23) chk("b2b_ct2", ct, Z_CT);
      if (i == 35) chk("b2b_ct3", ct, Z_CT);
    end
    start = 1'b0;
    chk("b2b_pulses", 128'(pulse_at.size()), 128'(3));
    if (pulse_at.size() == 3) begin
      chk("b2b_pulse1", 128'(pulse_at[0]), 128'(11));
      chk("b2b_pulse2", 128'(pulse_at[1]), 128'(23));
      chk("b2b_pulse3", 128'(pulse_at[2]), 128'(35));
    end
    repeat (2) @(negedge clk);

    // reset in the middle of round 5 discards the partial result
    set_key(C1_KEY); pt = C1_PT; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", 128'(busy), 128'h0);
    chk("midrst_ct", ct, 128'h0);
    chk("midrst_ct_valid", 128'(ct_valid), 128'h0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("midrst_no_pulse", 128'(ct_valid), 128'h0);
    end

    run_one("c1_again", C1_KEY, C1_PT, C1_CT, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
